zx_tape_saver: RTL

Tape SAVE capture block for the ZX80/ZX81 core, the counterpart of the tape loader path. It watches the machine's MIC output during SAVE, decodes the pulse-burst bit encoding into bytes, and stores them in a local buffer. The host reads the buffer out through a registered read port so the saved program can be uploaded as a .p/.o image. It sits next to the sync generator, is clocked on clk_sys, and samples on the 6.5 MHz ce_65 enable.

---
 rtl/zx_tape_saver.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/zx_tape_saver.sv
// Tape SAVE capture: decodes ZX80/ZX81 MIC pulse bursts into bytes and buffers
// them for host readout through a registered read port.
module zx_tape_saver #(
    parameter int ADDR_W     = 14,
    parameter int PULSE_MIN  = 300,
    parameter int PULSE_MAX  = 2000,
    parameter int BIT_GAP    = 3900,
    parameter int END_GAP    = 65000,
    parameter int ONE_THRESH = 7
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ce,
    input  logic              en,
    input  logic              mic,
    input  logic              host_clear,
    input  logic [ADDR_W-1:0] host_rd_addr,
    output logic [7:0]        host_rd_data,
    output logic [ADDR_W:0]   byte_count,
    output logic              save_done,
    output logic              overflow,
    output logic              partial_err,
    output logic              busy
);

    localparam int SIL_W = $clog2(END_GAP + 1);
    localparam int BC_W  = ADDR_W + 1;

    localparam logic [11:0]      P_MIN   = 12'(PULSE_MIN);
    localparam logic [11:0]      P_MAX   = 12'(PULSE_MAX);
    localparam logic [11:0]      W_SAT   = 12'hFFF;
    localparam logic [SIL_W-1:0] GAP_BIT = SIL_W'(BIT_GAP);
    localparam logic [SIL_W-1:0] GAP_END = SIL_W'(END_GAP);
    localparam logic [SIL_W-1:0] SIL_ONE = SIL_W'(1);
    localparam logic [BC_W-1:0]  BC_ONE  = BC_W'(1);
    localparam logic [3:0]       ONE_T   = 4'(ONE_THRESH);

    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_DONE} state_t;

    state_t state_r, fsm_next_s, next_s;

    logic              ms_meta_r, ms_r, ms_prev_r;
    logic [11:0]       width_r;
    logic [SIL_W-1:0]  sil_r, sil_inc_s;
    logic [3:0]        pulse_cnt_r;
    logic [6:0]        shift_r;
    logic [2:0]        bit_cnt_r;
    logic [ADDR_W:0]   byte_count_r;
    logic              save_done_r, overflow_r, partial_err_r, busy_r;
    logic [7:0]        rd_data_r;
    logic [7:0]        mem [0:(1<<ADDR_W)-1];

    logic rise_s, fall_s;
    logic width_clr_s, width_inc_s, pulse_clr_s, pulse_inc_s;
    logic sil_clr_s, sil_inc_en_s, emit_s, bit_val_s, end_done_s;
    logic clear_s, byte_full_s, wr_en_s;
    logic [7:0] wr_byte_s;

    assign rise_s      = ce & ms_r & ~ms_prev_r;
    assign fall_s      = ce & ~ms_r & ms_prev_r;
    assign sil_inc_s   = (sil_r == GAP_END) ? sil_r : sil_r + SIL_ONE;
    assign clear_s     = reset | host_clear;
    assign byte_full_s = (bit_cnt_r == 3'd7);
    assign wr_byte_s   = {shift_r, bit_val_s};
    assign wr_en_s     = en & emit_s & byte_full_s & ~byte_count_r[ADDR_W] & ~clear_s;
    assign next_s      = en ? fsm_next_s : S_IDLE;

    // Two-flop synchronizer; the previous sample only advances on ce
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ms_meta_r <= 1'b0;
            ms_r      <= 1'b0;
            ms_prev_r <= 1'b0;
        end else begin
            ms_meta_r <= mic;
            ms_r      <= ms_meta_r;
            if (ce) begin
                ms_prev_r <= ms_r;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk_sys) begin
        if (clear_s) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        fsm_next_s   = state_r;
        width_clr_s  = 1'b0;
        width_inc_s  = 1'b0;
        pulse_clr_s  = 1'b0;
        pulse_inc_s  = 1'b0;
        sil_clr_s    = 1'b0;
        sil_inc_en_s = 1'b0;
        emit_s       = 1'b0;
        bit_val_s    = 1'b0;
        end_done_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (rise_s) begin
                    fsm_next_s  = S_HIGH;
                    width_clr_s = 1'b1;
                    pulse_clr_s = 1'b1;
                end else begin
                    fsm_next_s = S_IDLE;
                end
            end
            S_HIGH: begin
                if (fall_s) begin
                    fsm_next_s = S_LOW;
                    sil_clr_s  = 1'b1;
                    if ((width_r >= P_MIN) && (width_r <= P_MAX)) begin
                        pulse_inc_s = 1'b1;
                    end else begin
                        pulse_clr_s = 1'b1;
                    end
                end else begin
                    width_inc_s = ce;
                end
            end
            S_LOW: begin
                if (ce) begin
                    sil_inc_en_s = 1'b1;
                    // Bit decision comes before a coincident rising edge is taken
                    if ((sil_inc_s == GAP_BIT) && (pulse_cnt_r != 4'd0)) begin
                        emit_s      = 1'b1;
                        bit_val_s   = (pulse_cnt_r >= ONE_T);
                        pulse_clr_s = 1'b1;
                    end else begin
                        emit_s = 1'b0;
                    end
                    if (rise_s) begin
                        fsm_next_s  = S_HIGH;
                        width_clr_s = 1'b1;
                    end else if (sil_inc_s == GAP_END) begin
                        if (byte_count_r != '0) begin
                            fsm_next_s = S_DONE;
                            end_done_s = 1'b1;
                        end else begin
                            fsm_next_s = S_IDLE;
                        end
                    end else begin
                        fsm_next_s = S_LOW;
                    end
                end else begin
                    fsm_next_s = S_LOW;
                end
            end
            S_DONE: begin
                fsm_next_s = S_DONE;
            end
            default: begin
                fsm_next_s = S_IDLE;
            end
        endcase
    end

    // Counters, byte assembly and status flags
    always_ff @(posedge clk_sys) begin
        if (clear_s) begin
            width_r       <= 12'd0;
            sil_r         <= '0;
            pulse_cnt_r   <= 4'd0;
            shift_r       <= 7'd0;
            bit_cnt_r     <= 3'd0;
            byte_count_r  <= '0;
            save_done_r   <= 1'b0;
            overflow_r    <= 1'b0;
            partial_err_r <= 1'b0;
            busy_r        <= 1'b0;
        end else if (!en) begin
            pulse_cnt_r <= 4'd0;
            shift_r     <= 7'd0;
            bit_cnt_r   <= 3'd0;
            busy_r      <= 1'b0;
        end else begin
            busy_r <= (next_s == S_HIGH) || (next_s == S_LOW);

            if (width_clr_s) begin
                width_r <= 12'd0;
            end else if (width_inc_s && (width_r != W_SAT)) begin
                width_r <= width_r + 12'd1;
            end

            if (sil_clr_s) begin
                sil_r <= '0;
            end else if (sil_inc_en_s) begin
                sil_r <= sil_inc_s;
            end

            if (pulse_clr_s) begin
                pulse_cnt_r <= 4'd0;
            end else if (pulse_inc_s && (pulse_cnt_r != 4'hF)) begin
                pulse_cnt_r <= pulse_cnt_r + 4'd1;
            end

            if (emit_s) begin
                shift_r   <= wr_byte_s[6:0];
                bit_cnt_r <= bit_cnt_r + 3'd1;
                if (byte_full_s) begin
                    if (!byte_count_r[ADDR_W]) begin
                        byte_count_r <= byte_count_r + BC_ONE;
                    end else begin
                        overflow_r <= 1'b1;
                    end
                end
            end else if (end_done_s) begin
                save_done_r   <= 1'b1;
                partial_err_r <= partial_err_r | (bit_cnt_r != 3'd0);
                bit_cnt_r     <= 3'd0;
                shift_r       <= 7'd0;
            end
        end
    end

    // Buffer write port
    always_ff @(posedge clk_sys) begin
        if (wr_en_s) begin
            mem[byte_count_r[ADDR_W-1:0]] <= wr_byte_s;
        end
    end

    // Registered host read port
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            rd_data_r <= 8'd0;
        end else begin
            rd_data_r <= mem[host_rd_addr];
        end
    end

    assign host_rd_data = rd_data_r;
    assign byte_count   = byte_count_r;
    assign save_done    = save_done_r;
    assign overflow     = overflow_r;
    assign partial_err  = partial_err_r;
    assign busy         = busy_r;

endmodule
